// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and constants for the data-memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam int         MAX_LATENCY = 15;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    // Fibonacci taps 8,6,5,4 map to state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// dmem_if : LSU <-> data-memory request/response handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_if;
    logic        reqValid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        respValid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output reqValid, req_wen, req_addr, req_wdata, req_wmask,
        input  respValid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  reqValid, req_wen, req_addr, req_wdata, req_wmask,
        output respValid, resp_rdata, resp_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// dmem_array : word-organised RAM with byte-lane write enables
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clock,
    input  wire logic             we,
    input  wire logic [3:0]       wmask,
    input  wire logic [IDX_W-1:0] windex,
    input  wire logic [31:0]      wdata,
    output logic      [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    r_mem[windex][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Index is held stable by the responder for the whole transaction
    assign rdata = r_mem[windex];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : target end of the LSU reqValid/respValid handshake.
// Optional: DMEM_RAND_DELAY_EN adds 0..3 LFSR-driven extra latency cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    dmem_if.slave     bus
);

    localparam int          c_IDX_W  = $clog2(DEPTH);
    localparam logic [32:0] c_BASE33 = {1'b0, BASE};

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("dmem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end

    dmem_state_t        r_state;
    dmem_state_t        w_next;
    logic [4:0]         r_count;
    logic [c_IDX_W-1:0] r_index;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wmask;
    logic               r_wen;
    logic               r_err;
    logic [31:0]        r_rdata_hold;

    logic [32:0]        w_off;
    logic               w_in_range;
    logic               w_accept;
    logic [1:0]         w_extra;
    logic [4:0]         w_delay;
    logic [31:0]        w_arr_rdata;
    logic               w_we;
    logic               w_resp_valid;
    logic [31:0]        w_resp_rdata;
    logic               w_resp_err;
    logic               w_busy;
    logic               w_unused;

    // 33-bit offset so addresses below BASE show up as a negative result
    assign w_off      = {1'b0, bus.req_addr} - c_BASE33;
    assign w_in_range = !w_off[32] && (w_off[31:c_IDX_W+2] == '0);
    assign w_unused   = ^w_off[1:0];
    assign w_accept   = (r_state == DMEM_IDLE) && bus.reqValid;

`ifdef DMEM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    assign w_delay = 5'(LATENCY) + {3'b000, w_extra};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DMEM_IDLE: if (bus.reqValid) w_next = (w_delay == 5'd1) ? DMEM_RESP : DMEM_WAIT;
            DMEM_WAIT: if (r_count == 5'd0) w_next = DMEM_RESP;
            DMEM_RESP: w_next = DMEM_IDLE;
            default:   w_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count      <= 5'd0;
            r_index      <= '0;
            r_wdata      <= 32'd0;
            r_wmask      <= 4'd0;
            r_wen        <= 1'b0;
            r_err        <= 1'b0;
            r_rdata_hold <= 32'd0;
        end else begin
            if (w_accept) begin
                r_count <= (w_delay > 5'd1) ? (w_delay - 5'd2) : 5'd0;
                r_index <= w_off[c_IDX_W+1:2];
                r_wdata <= bus.req_wdata;
                r_wmask <= bus.req_wmask;
                r_wen   <= bus.req_wen;
                r_err   <= !w_in_range;
            end else if (r_state == DMEM_WAIT && r_count != 5'd0) begin
                r_count <= r_count - 5'd1;
            end
            // Keep the last response word visible between transactions
            if (r_state == DMEM_RESP) begin
                r_rdata_hold <= w_resp_rdata;
            end
        end
    end

    // Write lands on the edge closing RESP, after the pre-write word was returned
    assign w_we = (r_state == DMEM_RESP) && r_wen && !r_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_array (
        .clock  (clock),
        .we     (w_we),
        .wmask  (r_wmask),
        .windex (r_index),
        .wdata  (r_wdata),
        .rdata  (w_arr_rdata)
    );

    always_comb begin
        w_resp_valid = (r_state == DMEM_RESP);
        w_busy       = (r_state != DMEM_IDLE);
        w_resp_err   = w_resp_valid && r_err;
        w_resp_rdata = r_rdata_hold;
        if (w_resp_valid) begin
            w_resp_rdata = r_err ? 32'd0 : w_arr_rdata;
        end
    end

    assign bus.respValid  = w_resp_valid;
    assign bus.resp_rdata = w_resp_rdata;
    assign bus.resp_err   = w_resp_err;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : directed vectors for dmem_responder (LATENCY 2 and 1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int LAT0 = 2;
    localparam int NV   = 18;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    dmem_if b0();
    dmem_if b1();

    dmem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(LAT0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (b0)
    );

    dmem_responder #(.DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        chk;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat);
        tests++;
`ifdef DMEM_RAND_DELAY_EN
        if (lat < LAT0 || lat > LAT0 + 3) begin
`else
        if (lat != LAT0) begin
`endif
            fails++;
            $display("FAIL %s: latency got %0d expected %0d", name, lat, LAT0);
        end
    endtask

    // Issue one request on dut0 and wait (bounded) for its response
    task automatic req0(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output int lat, output logic [31:0] rdata,
                        output logic err);
        @(negedge clock);
        b0.reqValid  = 1'b1;
        b0.req_wen   = wen;
        b0.req_addr  = addr;
        b0.req_wdata = wdata;
        b0.req_wmask = wmask;
        @(negedge clock);
        b0.reqValid = 1'b0;
        lat = 1;
        while (!b0.respValid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        if (!b0.respValid) lat = -1;
        rdata = b0.resp_rdata;
        err   = b0.resp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          pulses;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_AA00, 4'h2, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1122_3344, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h1122_3344, 1'b0};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1122_3344, 1'b0};
        vecs[12] = '{1'b1, 32'h8000_0FFE, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[13] = '{1'b1, 32'h8000_0FFC, 32'h00BB_0000, 4'h4, 1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[14] = '{1'b1, 32'h8000_0FFC, 32'h0000_00CC, 4'h1, 1'b1, 32'hA5BB_A5A5, 1'b0};
        vecs[15] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 1'b1, 32'hA5BB_A5CC, 1'b0};
        vecs[16] = '{1'b1, 32'h8000_0004, 32'h0101_0101, 4'hF, 1'b0, 32'h0,         1'b0};
        vecs[17] = '{1'b1, 32'h8000_0008, 32'h0202_0202, 4'hF, 1'b0, 32'h0,         1'b0};

        b0.reqValid = 1'b0; b0.req_wen = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.req_wmask = '0;
        b1.reqValid = 1'b0; b1.req_wen = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_wmask = '0;

        repeat (3) @(negedge clock);
        chk("reset_respValid", {31'd0, b0.respValid}, 32'd0);
        chk("reset_rdata",     b0.resp_rdata,         32'd0);
        chk("reset_err",       {31'd0, b0.resp_err},  32'd0);
        chk("reset_busy",      {31'd0, b0.busy},      32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req0(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, lat, rd, er);
            chk_lat($sformatf("vec%0d_lat", i), lat);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            if (i == 15) begin
                @(negedge clock);
                chk("hold_rdata",     b0.resp_rdata,         32'hA5BB_A5CC);
                chk("hold_respValid", {31'd0, b0.respValid}, 32'd0);
            end
        end

`ifdef DMEM_RAND_DELAY_EN
        begin
            int run1 [16];
            for (int pass = 0; pass < 2; pass++) begin
                @(negedge clock); reset = 1'b1;
                @(negedge clock); reset = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    req0(1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, er);
                    chk_lat($sformatf("rand%0d_lat", k), lat);
                    if (pass == 0) run1[k] = lat;
                    else chk($sformatf("rand%0d_repeat", k), lat, run1[k]);
                end
            end
        end
`else
        // Two-beat sequence with stray strobes in WAIT and RESP
        @(negedge clock);
        b0.reqValid = 1'b1; b0.req_wen = 1'b0; b0.req_addr = 32'h8000_0004;
        @(negedge clock);
        b0.req_addr = 32'h8000_0010;
        chk("seq_wait_busy",  {31'd0, b0.busy},      32'd1);
        chk("seq_wait_resp",  {31'd0, b0.respValid}, 32'd0);
        @(negedge clock);
        chk("seq_beat1_resp",  {31'd0, b0.respValid}, 32'd1);
        chk("seq_beat1_rdata", b0.resp_rdata,         32'h0101_0101);
        @(negedge clock);
        chk("seq_no_extra",    {31'd0, b0.respValid}, 32'd0);
        b0.req_addr = 32'h8000_0008;
        @(negedge clock);
        b0.reqValid = 1'b0;
        chk("seq_beat2_wait",  {31'd0, b0.respValid}, 32'd0);
        @(negedge clock);
        chk("seq_beat2_resp",  {31'd0, b0.respValid}, 32'd1);
        chk("seq_beat2_rdata", b0.resp_rdata,         32'h0202_0202);
        @(negedge clock);
        chk("seq_after_resp",  {31'd0, b0.respValid}, 32'd0);

        // LATENCY=1 instance
        chk("l1_idle_busy", {31'd0, b1.busy}, 32'd0);
        b1.reqValid = 1'b1; b1.req_wen = 1'b1; b1.req_addr = 32'h8000_0020;
        b1.req_wdata = 32'hCAFE_F00D; b1.req_wmask = 4'hF;
        @(negedge clock);
        b1.reqValid = 1'b0;
        chk("l1_resp",      {31'd0, b1.respValid}, 32'd1);
        chk("l1_busy_resp", {31'd0, b1.busy},      32'd1);
        @(negedge clock);
        chk("l1_resp_done", {31'd0, b1.respValid}, 32'd0);
        chk("l1_busy_done", {31'd0, b1.busy},      32'd0);
        b1.reqValid = 1'b1; b1.req_wen = 1'b0;
        @(negedge clock);
        b1.reqValid = 1'b0;
        chk("l1_rd_resp",  {31'd0, b1.respValid}, 32'd1);
        chk("l1_rd_rdata", b1.resp_rdata,         32'hCAFE_F00D);
`endif

        // Reset while a write is waiting: no response, no write
        @(negedge clock);
        b0.reqValid = 1'b1; b0.req_wen = 1'b1; b0.req_addr = 32'h8000_0010;
        b0.req_wdata = 32'h1234_5678; b0.req_wmask = 4'hF;
        @(negedge clock);
        b0.reqValid = 1'b0;
        chk("rst_pre_busy", {31'd0, b0.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_busy", {31'd0, b0.busy}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (b0.respValid) pulses++;
        end
        chk("rst_no_resp", pulses, 0);
        chk("rst_rdata",   b0.resp_rdata, 32'd0);
        req0(1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, er);
        chk("rst_old_word", rd, 32'hDEAD_AAEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
